// File: rtl/seq_pattern_tx.sv
// Serial test-pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, repeat_n times.
// Optional SEQ_TX_GAP_EN inserts GAP_LEN zero line bits between consecutive repeats.
module seq_pattern_tx #(
   parameter int PAT_W   = 4,
   parameter int CNT_W   = 4,
   parameter int GAP_LEN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             dout,
   output logic             dout_valid,
   output logic             last_bit,
   output logic             busy,
   output logic             done
);
   localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam int GAP_W = $clog2(GAP_LEN + 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t             state, state_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [CNT_W-1:0]   rep, rep_n;
   logic [PAT_W-1:0]   pat_q, pat_n;
   logic [GAP_W-1:0]   gap_cnt, gap_n;
   logic               dout_d, dout_valid_d, last_bit_d, busy_d, done_d;

   // Registers hold the state being presented on the outputs in the current cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         rep        <= '0;
         pat_q      <= '0;
         gap_cnt    <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         last_bit   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         rep        <= rep_n;
         pat_q      <= pat_n;
         gap_cnt    <= gap_n;
         dout       <= dout_d;
         dout_valid <= dout_valid_d;
         last_bit   <= last_bit_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      rep_n   = rep;
      pat_n   = pat_q;
      gap_n   = gap_cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               pat_n   = pattern;
               rep_n   = repeat_n;
               idx_n   = IDX_W'(PAT_W - 1);
               state_n = (repeat_n == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            if (idx == '0) begin
               rep_n = rep - 1'b1;
               if (rep == CNT_W'(1)) begin
                  state_n = DONE;
               end else begin
`ifdef SEQ_TX_GAP_EN
                  state_n = GAP;
                  gap_n   = GAP_W'(GAP_LEN - 1);
`else
                  state_n = SEND;
                  idx_n   = IDX_W'(PAT_W - 1);
`endif
               end
            end else begin
               idx_n = idx - 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_n = SEND;
               idx_n   = IDX_W'(PAT_W - 1);
            end else begin
               gap_n = gap_cnt - 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Output values for the next cycle, derived from the next state.
   always_comb begin
      dout_valid_d = (state_n == SEND) || (state_n == GAP);
      dout_d       = (state_n == SEND) ? pat_n[idx_n] : 1'b0;
      last_bit_d   = (state_n == SEND) && (idx_n == '0) && (rep_n == CNT_W'(1));
      busy_d       = (state_n != IDLE);
      done_d       = (state_n == DONE);
   end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: table of bursts plus hand-written reset corner cases.
module tb_seq_pattern_tx;
   localparam int PAT_W = 4, CNT_W = 4, GAP_LEN = 2;
`ifdef SEQ_TX_GAP_EN
   localparam int GAPS = GAP_LEN;
`else
   localparam int GAPS = 0;
`endif

   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [PAT_W-1:0] pattern = '0;
   logic [CNT_W-1:0] repeat_n = '0;
   logic dout, dout_valid, last_bit, busy, done;

   seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
      .clk(clk), .reset(reset), .start(start), .pattern(pattern), .repeat_n(repeat_n),
      .dout(dout), .dout_valid(dout_valid), .last_bit(last_bit), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PAT_W-1:0] pat;
      logic [CNT_W-1:0] rep;
      bit               poke;
      int               len_nogap;
   } vec_t;

   vec_t        vecs[6];
   logic [1:0]  sb[$];   // {expected dout, expected last_bit}
   int          n_chk = 0, n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push_model(input logic [PAT_W-1:0] p, input int r);
      for (int i = 0; i < r; i++) begin
         if (i > 0) for (int g = 0; g < GAPS; g++) sb.push_back(2'b00);
         for (int k = PAT_W - 1; k >= 0; k--)
            sb.push_back({p[k], (i == r - 1) && (k == 0)});
      end
   endtask

   task automatic sample_line(input string tag);
      logic [1:0] e;
      if (dout_valid) begin
         if (sb.size() == 0) begin
            check({tag, " unexpected valid"}, 1, 0);
         end else begin
            e = sb.pop_front();
            check({tag, " dout"}, int'(dout), int'(e[1]));
            check({tag, " last_bit"}, int'(last_bit), int'(e[0]));
         end
      end else begin
         check({tag, " idle dout"}, int'(dout), 0);
      end
   endtask

   task automatic burst(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                        input bit poke, input int exp_len);
      int cyc, nvalid, exp_done;
      bit seen;
      exp_done = (r == 0) ? 1 : exp_len + 1;
      push_model(p, int'(r));
      @(negedge clk);
      start = 1'b1; pattern = p; repeat_n = r;
      @(negedge clk);
      pattern = ~p; repeat_n = r + 1'b1;
      cyc = 1; nvalid = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
         sample_line("burst");
         if (dout_valid) nvalid++;
         check("busy during burst", int'(busy), 1);
         if (done) begin
            seen = 1'b1;
            check("done cycle", cyc, exp_done);
         end
         start = poke && (cyc <= 3);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!seen) check("done timeout", 0, 1);
      check("valid count", nvalid, exp_len);
      check("scoreboard drained", sb.size(), 0);
      check("busy after done", int'(busy), 0);
      check("done single pulse", int'(done), 0);
      sb.delete();
   endtask

   initial begin
      vecs[0] = '{4'b1101, 4'd1,  1'b0, 4};
      vecs[1] = '{4'b1101, 4'd2,  1'b0, 8};
      vecs[2] = '{4'b1101, 4'd0,  1'b0, 0};
      vecs[3] = '{4'b1101, 4'd1,  1'b1, 4};
      vecs[4] = '{4'b1010, 4'd3,  1'b0, 12};
      vecs[5] = '{4'b0110, 4'd15, 1'b0, 60};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst dout", int'(dout), 0);
      check("rst dout_valid", int'(dout_valid), 0);
      check("rst last_bit", int'(last_bit), 0);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle dout_valid", int'(dout_valid), 0);
         check("idle done", int'(done), 0);
      end

      foreach (vecs[i]) begin
         int len;
         len = vecs[i].len_nogap + ((vecs[i].rep > 0) ? GAPS * (int'(vecs[i].rep) - 1) : 0);
         burst(vecs[i].pat, vecs[i].rep, vecs[i].poke, len);
      end

      // Reset in cycle 3 of a two-repeat burst abandons it without done.
      push_model(4'b1101, 2);
      @(negedge clk);
      start = 1'b1; pattern = 4'b1101; repeat_n = 4'd2;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         sample_line("pre-reset");
         if (c < 3) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      check("mid rst dout", int'(dout), 0);
      check("mid rst dout_valid", int'(dout_valid), 0);
      check("mid rst last_bit", int'(last_bit), 0);
      check("mid rst busy", int'(busy), 0);
      check("mid rst done", int'(done), 0);
      reset = 1'b0;
      sb.delete();
      repeat (4) begin
         @(negedge clk);
         check("post rst no done", int'(done), 0);
         check("post rst no valid", int'(dout_valid), 0);
      end
      burst(4'b1101, 4'd1, 1'b0, 4);

      // Reset wins over start on the same edge.
      @(negedge clk);
      reset = 1'b1; start = 1'b1; pattern = 4'b1111; repeat_n = 4'd1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("rst prio busy", int'(busy), 0);
      check("rst prio valid", int'(dout_valid), 0);
      @(negedge clk);
      check("rst prio still idle", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
